// File: rtl/fp_div_pkg.sv
// fp_pkg: shared single-precision format constants, the fp32 field view and
// the divider FSM state encoding.
package fp_pkg;
    localparam int          FP_BIAS    = 127;
    localparam int          FP_EXP_W   = 8;
    localparam int          FP_MAN_W   = 23;
    localparam logic [31:0] FP_POS_INF = 32'h7F800000;

    typedef struct packed {
        logic                s;
        logic [FP_EXP_W-1:0] e;
        logic [FP_MAN_W-1:0] m;
    } fp32_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_NORM = 2'd2
    } div_state_e;
endpackage

// File: rtl/fp_div_if.sv
// fp_div_if: start/done handshake and operand/result bus of the FP divider.
//   master : drives start, a, b; observes busy, done, result, div_by_zero
//   slave  : the divider side
interface fp_div_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    modport master (output start, a, b, input busy, done, result, div_by_zero);
    modport slave  (input start, a, b, output busy, done, result, div_by_zero);
endinterface

// File: rtl/fp_div_mant.sv
// fp_mant_div: 25-step radix-2 restoring divider for 24-bit mantissas.
//   clk, rst : clock, async active-high reset
//   i_clr    : clear the iteration counter
//   i_load   : load remainder from i_ma, clear quotient and counter
//   i_step   : produce one quotient bit (MSB first)
//   i_ma/i_mb: dividend / divisor mantissas in [1,2), hidden bit included
//   o_q      : quotient, o_q[24] has weight 1
//   o_cnt    : number of steps taken since load
module fp_mant_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_load,
    input  logic        i_step,
    input  logic [23:0] i_ma,
    input  logic [23:0] i_mb,
    output logic [24:0] o_q,
    output logic [4:0]  o_cnt
);
    logic [25:0] r_rem;
    logic [24:0] r_q;
    logic [4:0]  r_cnt;
    logic [25:0] w_mb;
    logic        w_ge;
    logic [25:0] w_rem_nx;

    assign w_mb     = {2'b00, i_mb};
    assign w_ge     = (r_rem >= w_mb);
    // Remainder stays below 2*MB after each subtract, so the shift fits in 26 bits.
    assign w_rem_nx = (w_ge ? (r_rem - w_mb) : r_rem) << 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_q   <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_rem <= {2'b00, i_ma};
            r_q   <= '0;
            r_cnt <= '0;
        end else if (i_step) begin
            r_rem <= w_rem_nx;
            r_q   <= {r_q[23:0], w_ge};
            r_cnt <= r_cnt + 5'd1;
        end else if (i_clr) begin
            r_cnt <= '0;
        end
    end

    assign o_q   = r_q;
    assign o_cnt = r_cnt;
endmodule

// File: rtl/fp_div.sv
// fp_div: sequential single-precision divider, result = a / b, truncated.
//   clk, rst : clock, async active-high reset
//   bus      : fp_div_if.slave (start/a/b in; busy/done/result/div_by_zero out)
// Fixed 27-cycle latency from the accepting edge to done, special cases included.
module fp_div
    import fp_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    fp_div_if.slave  bus
);
    div_state_e  r_state, w_next;
    fp32_t       r_a, r_b;
    logic        r_first, r_busy, r_done, r_dz;
    logic [31:0] r_result;

    logic        w_accept, w_load, w_step;
    logic [24:0] w_q;
    logic [4:0]  w_cnt;
    logic        w_sign, w_a_zero, w_b_zero;
    logic signed [9:0] w_exp;
    logic [22:0] w_frac;
    logic [31:0] w_res;

    fp_mant_div u_mant (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_accept),
        .i_load (w_load),
        .i_step (w_step),
        .i_ma   ({1'b1, r_a.m}),
        .i_mb   ({1'b1, r_b.m}),
        .o_q    (w_q),
        .o_cnt  (w_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // First DIV cycle loads the mantissa divider from the latched operands,
    // the following 25 cycles each produce one quotient bit.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_load   = 1'b0;
        w_step   = 1'b0;
        case (r_state)
            ST_IDLE: if (bus.start) begin
                w_accept = 1'b1;
                w_next   = ST_DIV;
            end
            ST_DIV: begin
                if (r_first) begin
                    w_load = 1'b1;
                end else begin
                    w_step = 1'b1;
                    if (w_cnt == 5'd24) w_next = ST_NORM;
                end
            end
            ST_NORM: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_sign   = r_a.s ^ r_b.s;
    assign w_a_zero = (r_a.e == '0);
    assign w_b_zero = (r_b.e == '0);
    // Quotient of two [1,2) mantissas lies in (0.5,2): at most one left shift.
    assign w_exp    = $signed({2'b00, r_a.e}) - $signed({2'b00, r_b.e})
                    + (w_q[24] ? 10'sd127 : 10'sd126);
    assign w_frac   = w_q[24] ? w_q[23:1] : w_q[22:0];

    always_comb begin
        w_res = {w_sign, w_exp[7:0], w_frac};
        if (w_b_zero)             w_res = FP_POS_INF | {w_sign, 31'h0};
        else if (w_a_zero)        w_res = {w_sign, 31'h0};
        else if (w_exp >= 10'sd255) w_res = FP_POS_INF | {w_sign, 31'h0};
        else if (w_exp <= 10'sd0) w_res = {w_sign, 31'h0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_first  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_result <= '0;
        end else begin
            r_done <= 1'b0;
            // A start on the done cycle keeps busy high.
            if (w_accept) begin
                r_a     <= bus.a;
                r_b     <= bus.b;
                r_first <= 1'b1;
                r_busy  <= 1'b1;
            end else if (r_done) begin
                r_busy  <= 1'b0;
            end
            if (w_load) r_first <= 1'b0;
            if (r_state == ST_NORM) begin
                r_done   <= 1'b1;
                r_result <= w_res;
                r_dz     <= w_b_zero;
            end
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.result      = r_result;
    assign bus.div_by_zero = r_dz;
endmodule

// File: tb/tb_fp_div.sv
module tb_fp_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    fp_div_if bus();

    fp_div dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        dz;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: quotient as floor(MA * 2^24 / MB), then normalise and clamp.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [63:0] q;
        int          e;
        logic [22:0] frac;
        s = a[31] ^ b[31];
        if (b[30:23] == 8'd0) return {1'b1, s, 8'hFF, 23'h0};
        if (a[30:23] == 8'd0) return {1'b0, s, 31'h0};
        q = ({40'd0, 1'b1, a[22:0]} << 24) / {40'd0, 1'b1, b[22:0]};
        if (q[24]) begin
            e = int'(a[30:23]) - int'(b[30:23]) + 127;
            frac = q[23:1];
        end else begin
            e = int'(a[30:23]) - int'(b[30:23]) + 126;
            frac = q[22:0];
        end
        if (e >= 255) return {1'b0, s, 8'hFF, 23'h0};
        if (e <= 0)   return {1'b0, s, 31'h0};
        return {1'b0, s, e[7:0], frac};
    endfunction

    // Called at the negedge following the accepting edge T; iteration k samples
    // after edge T+k. mode 1 pokes start at k=5,20; mode 2 resets at k=10.
    task automatic wait_done(input int mode, output logic [31:0] res,
                             output logic dz, output int lat);
        lat = -1;
        res = '0;
        dz  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (mode == 1 && (k == 5 || k == 20)) begin
                bus.start = 1'b1;
                bus.a = 32'h42C80000;
                bus.b = 32'h3F800000;
            end
            @(negedge clk);
            bus.start = 1'b0;
            if (mode == 2 && k == 10) begin
                rst = 1'b1;
                #1;
                chk("rst_mid_busy", {31'h0, bus.busy}, 32'h0);
                chk("rst_mid_done", {31'h0, bus.done}, 32'h0);
                chk("rst_mid_result", bus.result, 32'h0);
                @(posedge clk);
                #1 rst = 1'b0;
            end
            if (bus.done === 1'b1) begin
                lat = k;
                res = bus.result;
                dz  = bus.div_by_zero;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int mode,
                          output logic [31:0] res, output logic dz, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a = a;
        bus.b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        chk("busy_after_start", {31'h0, bus.busy}, 32'h1);
        wait_done(mode, res, dz, lat);
    endtask

    initial begin
        logic [31:0] res;
        logic        dz;
        int          lat;
        logic [32:0] m;
        logic [31:0] ra, rb;
        int          extra;

        tbl[0] = '{"6div2",    32'h40C00000, 32'h40000000, 32'h40400000, 1'b0};
        tbl[1] = '{"1div3",    32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0};
        tbl[2] = '{"1div1p5",  32'h3F800000, 32'h3FC00000, 32'h3F2AAAAA, 1'b0};
        tbl[3] = '{"m8divp5",  32'hC1000000, 32'h3F000000, 32'hC1800000, 1'b0};
        tbl[4] = '{"divzero",  32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1};
        tbl[5] = '{"negzero",  32'h80000000, 32'h40000000, 32'h80000000, 1'b0};
        tbl[6] = '{"zerozero", 32'h00000000, 32'h00000000, 32'h7F800000, 1'b1};
        tbl[7] = '{"overflow", 32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0};
        tbl[8] = '{"underflow",32'h00800000, 32'h7F000000, 32'h00000000, 1'b0};
        tbl[9] = '{"negdivz",  32'h3F800000, 32'h80000000, 32'hFF800000, 1'b1};

        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy",   {31'h0, bus.busy}, 32'h0);
        chk("reset_done",   {31'h0, bus.done}, 32'h0);
        chk("reset_result", bus.result, 32'h0);
        chk("reset_dz",     {31'h0, bus.div_by_zero}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].a, tbl[i].b, 0, res, dz, lat);
            chk({tbl[i].name, "_lat"}, lat, 27);
            chk({tbl[i].name, "_res"}, res, tbl[i].res);
            chk({tbl[i].name, "_dz"},  {31'h0, dz}, {31'h0, tbl[i].dz});
            if (i == 0) begin
                @(negedge clk);
                chk("done_pulse_end", {31'h0, bus.done}, 32'h0);
                chk("busy_drop",      {31'h0, bus.busy}, 32'h0);
                chk("result_hold",    bus.result, 32'h40400000);
            end
        end

        // start while busy is ignored; exactly one done with original operands
        run_op(32'h40C00000, 32'h40000000, 1, res, dz, lat);
        chk("poke_lat", lat, 27);
        chk("poke_res", res, 32'h40400000);
        extra = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra++;
        end
        chk("poke_single_done", extra, 0);

        // back-to-back: start on the done cycle is accepted
        run_op(32'h3F800000, 32'h40400000, 0, res, dz, lat);
        chk("b2b_first_res", res, 32'h3EAAAAAA);
        bus.start = 1'b1;
        bus.a = 32'hC1000000;
        bus.b = 32'h3F000000;
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_busy_kept", {31'h0, bus.busy}, 32'h1);
        chk("b2b_done_low",  {31'h0, bus.done}, 32'h0);
        wait_done(0, res, dz, lat);
        chk("b2b_second_lat", lat, 27);
        chk("b2b_second_res", res, 32'hC1800000);

        // reset mid-operation aborts with no done; next op completes
        run_op(32'h40C00000, 32'h40000000, 2, res, dz, lat);
        chk("rst_no_done", lat, -1);
        run_op(32'h3F800000, 32'h3FC00000, 0, res, dz, lat);
        chk("after_rst_lat", lat, 27);
        chk("after_rst_res", res, 32'h3F2AAAAA);

        // random operands against the reference model
        for (int i = 0; i < 200; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 15) == 0) ra[30:23] = 8'd0;
            if ($urandom_range(0, 15) == 0) rb[30:23] = 8'd0;
            m = model(ra, rb);
            run_op(ra, rb, 0, res, dz, lat);
            chk("rand_lat", lat, 27);
            chk("rand_res", res, m[31:0]);
            chk("rand_dz",  {31'h0, dz}, {31'h0, m[32]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
